// File: rtl/addsub_clip_stream.sv
// addsub_clip_stream
// Multi-channel signed add/subtract with saturation to WIDTH bits, behind a
// two-stage valid/ready pipeline:
//   stage 1 : full-precision (WIDTH+1) add or subtract per channel
//   stage 2 : clip to WIDTH bits, register sum/clip/out_valid
// Channels are packed LSB-first (channel k = bits [k*WIDTH +: WIDTH]) and are
// fully independent; the add/sub select applies to every channel of a beat.
// Sticky per-channel clip flags record clipped beats that were actually
// handed off downstream.
//
// Optional feature macro: ADDSUB_CLIP_STATS_EN
//   defined   -> clip_count port and saturating clipped-beat counter present
//   undefined -> no clip_count port, no counter logic

module addsub_clip_stream #(
    parameter int WIDTH     = 16,
    parameter int NCH       = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in1,
    input  logic [NCH*WIDTH-1:0]   in2,
    input  logic                   in_sub,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NCH*WIDTH-1:0]   sum,
    output logic [NCH-1:0]         clip,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr_flags,
    output logic [NCH-1:0]         clip_flag
`ifdef ADDSUB_CLIP_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]   clip_count
`endif
);

    localparam int EW = WIDTH + 1;   // extended (full-precision) width

    // ------------------------------------------------------------------
    // Saturation helper.
    // Input is a WIDTH+1 bit two's-complement result. The value fits in
    // WIDTH bits exactly when the top two bits agree; otherwise the top bit
    // tells the direction of overflow. Returns {clipped, value[WIDTH-1:0]}.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH:0] sat_fn(input logic [WIDTH:0] r);
        logic [WIDTH:0] res;
        if (r[WIDTH] != r[WIDTH-1]) begin
            if (r[WIDTH] == 1'b0) begin
                // positive overflow -> MAX = 0111..1
                res = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                // negative overflow -> MIN = 1000..0
                res = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            res = {1'b0, r[WIDTH-1:0]};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                   s1_valid_q;
    logic [NCH*EW-1:0]      s1_res_q;
    logic [NCH*EW-1:0]      s1_res_d;

    logic                   out_valid_q;
    logic [NCH*WIDTH-1:0]   sum_q;
    logic [NCH*WIDTH-1:0]   sum_d;
    logic [NCH-1:0]         clip_q;
    logic [NCH-1:0]         clip_d;

    logic [NCH-1:0]         clip_flag_q;
    logic [NCH-1:0]         clip_flag_d;

    logic                   s1_adv;
    logic                   s2_adv;
    logic                   out_hs;

    logic [EW-1:0]          a_ext;
    logic [EW-1:0]          b_ext;
    logic [EW-1:0]          sat_v;

    // Advance chain: an empty or draining stage 2 pulls stage 1, and an
    // empty or advancing stage 1 accepts a new beat. No skid buffer, so
    // in_ready follows out_ready combinationally.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign clip      = clip_q;
    assign clip_flag = clip_flag_q;

    // Stage 1 datapath: sign-extend each channel and add or subtract at
    // full precision so no intermediate overflow is possible.
    always_comb begin
        s1_res_d = '0;
        a_ext    = '0;
        b_ext    = '0;
        for (int k = 0; k < NCH; k++) begin
            a_ext = {in1[k*WIDTH+WIDTH-1], in1[k*WIDTH +: WIDTH]};
            b_ext = {in2[k*WIDTH+WIDTH-1], in2[k*WIDTH +: WIDTH]};
            if (in_sub) begin
                s1_res_d[k*EW +: EW] = a_ext - b_ext;
            end else begin
                s1_res_d[k*EW +: EW] = a_ext + b_ext;
            end
        end
    end

    // Stage 2 datapath: clip every channel of the stage-1 result.
    always_comb begin
        sum_d  = '0;
        clip_d = '0;
        sat_v  = '0;
        for (int k = 0; k < NCH; k++) begin
            sat_v                  = sat_fn(s1_res_q[k*EW +: EW]);
            sum_d[k*WIDTH +: WIDTH] = sat_v[WIDTH-1:0];
            clip_d[k]              = sat_v[WIDTH];
        end
    end

    // Sticky flag next state: a handshaken clipped beat sets its channel's
    // flag; clr_flags wipes the rest, and a set in the same cycle wins.
    always_comb begin
        clip_flag_d = clip_flag_q;
        if (clr_flags) begin
            clip_flag_d = '0;
        end else begin
            clip_flag_d = clip_flag_q;
        end
        if (out_hs) begin
            clip_flag_d = clip_flag_d | clip_q;
        end else begin
            clip_flag_d = clip_flag_d;
        end
    end

    // Pipeline registers: stage 1 loads on s1_adv, stage 2 on s2_adv;
    // data registers only capture when a valid beat moves in, so a stalled
    // output holds sum/clip/out_valid untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_res_q    <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            clip_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_res_q <= s1_res_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q  <= sum_d;
                    clip_q <= clip_d;
                end
            end
        end
    end

    // Sticky clip flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_flag_q <= '0;
        end else begin
            clip_flag_q <= clip_flag_d;
        end
    end

`ifdef ADDSUB_CLIP_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] clip_count_q;
    logic [CNT_WIDTH-1:0] clip_count_d;
    logic                 cnt_inc;

    // At most one count per beat, regardless of how many channels clipped.
    assign cnt_inc    = out_hs && (|clip_q);
    assign clip_count = clip_count_q;

    // Counter next state: clear restarts from the current beat (0 or 1),
    // otherwise increment and saturate at all-ones.
    always_comb begin
        clip_count_d = clip_count_q;
        if (clr_flags) begin
            if (cnt_inc) begin
                clip_count_d = CNT_ONE;
            end else begin
                clip_count_d = '0;
            end
        end else if (cnt_inc && (clip_count_q != CNT_MAX)) begin
            clip_count_d = clip_count_q + CNT_ONE;
        end else begin
            clip_count_d = clip_count_q;
        end
    end

    // Clipped-beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_clip_stream.sv
// Directed self-checking bench for addsub_clip_stream (WIDTH=16, NCH=2,
// CNT_WIDTH=3). Counter checks are active only when ADDSUB_CLIP_STATS_EN
// is defined for the build.

module tb_addsub_clip_stream;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        in_sub;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sum;
    logic [1:0]  clip;
    logic        out_valid;
    logic        out_ready;
    logic        clr_flags;
    logic [1:0]  clip_flag;
`ifdef ADDSUB_CLIP_STATS_EN
    logic [2:0]  clip_count;
`endif

    int checks = 0;
    int errors = 0;

    addsub_clip_stream #(
        .WIDTH     (16),
        .NCH       (2),
        .CNT_WIDTH (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in1        (in1),
        .in2        (in2),
        .in_sub     (in_sub),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum        (sum),
        .clip       (clip),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr_flags  (clr_flags),
        .clip_flag  (clip_flag)
`ifdef ADDSUB_CLIP_STATS_EN
        ,
        .clip_count (clip_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
        in1      = a;
        in2      = b;
        in_sub   = s;
        in_valid = 1'b1;
    endtask

    int          tx;
    int          rx;
    logic        saw_full;
    logic        prev_stall;
    logic [31:0] held_sum;

    initial begin
        rst_n     = 1'b0;
        in1       = 32'd0;
        in2       = 32'd0;
        in_sub    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        #12;
        // ---------------- reset state ----------------
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_clip", clip, 2'b00);
        chk("rst_clip_flag", clip_flag, 2'b00);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef ADDSUB_CLIP_STATS_EN
        chk("rst_clip_count", clip_count, 3'd0);
`endif
        rst_n = 1'b1;
        tick();

        // ---------------- 1: basic add, latency ----------------
        drive({16'hFFFB, 16'd100}, {16'd3, 16'd200}, 1'b0);
        #1;
        chk("basic_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("basic_lat1_out_valid", out_valid, 1'b0);
        tick();
        chk("basic_out_valid", out_valid, 1'b1);
        chk("basic_sum", sum, {16'hFFFE, 16'h012C});
        chk("basic_clip", clip, 2'b00);
        tick();
        chk("basic_drained", out_valid, 1'b0);

        // ---------------- 2: clipping both directions ----------------
        // ch0: 32767 - (-1) -> 32767 clip ; ch1: -32768 - 1 -> -32768 clip
        drive({16'h8000, 16'h7FFF}, {16'h0001, 16'hFFFF}, 1'b1);
        tick();
        // ch0: 0 - MIN -> MAX clip ; ch1: MIN - MIN -> 0 no clip
        drive({16'h8000, 16'h0000}, {16'h8000, 16'h8000}, 1'b1);
        tick();
        // exact limits without clipping: 16383+16384, -16384+-16384
        drive({16'hC000, 16'h3FFF}, {16'hC000, 16'h4000}, 1'b0);
        chk("clip_out_valid", out_valid, 1'b1);
        chk("clip_sum", sum, {16'h8000, 16'h7FFF});
        chk("clip_clip", clip, 2'b11);
        tick();
        in_valid = 1'b0;
        chk("subedge_sum", sum, {16'h0000, 16'h7FFF});
        chk("subedge_clip", clip, 2'b01);
        chk("clip_flag_set", clip_flag, 2'b11);
`ifdef ADDSUB_CLIP_STATS_EN
        chk("clip_count_one", clip_count, 3'd1);
`endif
        tick();
        chk("limit_sum", sum, {16'h8000, 16'h7FFF});
        chk("limit_clip", clip, 2'b00);
        tick();
        chk("limit_flag_kept", clip_flag, 2'b11);
`ifdef ADDSUB_CLIP_STATS_EN
        chk("clip_count_two", clip_count, 3'd2);
`endif
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_flag", clip_flag, 2'b00);
`ifdef ADDSUB_CLIP_STATS_EN
        chk("clr_count", clip_count, 3'd0);
`endif

        // ---------------- 3: backpressure stream ----------------
        tx         = 0;
        rx         = 0;
        saw_full   = 1'b0;
        prev_stall = 1'b0;
        held_sum   = 32'd0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (tx < 8);
            in1       = {16'(tx), 16'(tx * 10)};
            in2       = {16'd0, 16'd1};
            in_sub    = 1'b0;
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", out_valid, 1'b1);
                chk("bp_hold_sum", sum, held_sum);
            end
            if (out_valid && out_ready) begin
                chk("bp_data", sum, {16'(rx), 16'(rx * 10 + 1)});
                rx++;
            end
            if (!in_ready) begin
                saw_full = 1'b1;
                chk("bp_full_stalled", {out_valid, out_ready}, 2'b10);
            end
            prev_stall = out_valid && !out_ready;
            held_sum   = sum;
            if (in_valid && in_ready) begin
                tx++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_rx_count", 64'(rx), 64'd8);
        chk("bp_tx_count", 64'(tx), 64'd8);
        chk("bp_saw_full", saw_full, 1'b1);
        chk("bp_no_dup", out_valid, 1'b0);
        chk("bp_no_flag", clip_flag, 2'b00);

        // ---------------- 4: flag set/clear race ----------------
        drive({16'h0000, 16'h7FFF}, {16'h0000, 16'h0001}, 1'b0);   // ch0 clips
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("race_pre_flag", clip_flag, 2'b01);
        drive({16'h7FFF, 16'h0000}, {16'h0001, 16'h0000}, 1'b0);   // ch1 clips
        tick();
        in_valid = 1'b0;
        tick();
        chk("race_beat_clip", clip, 2'b10);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("race_flag", clip_flag, 2'b10);
`ifdef ADDSUB_CLIP_STATS_EN
        chk("race_count", clip_count, 3'd1);
`endif

        // ---------------- 6: counter saturation ----------------
        drive({16'h8000, 16'h7FFF}, {16'hFFFF, 16'h0001}, 1'b0);   // both clip
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("sat_flag", clip_flag, 2'b11);
`ifdef ADDSUB_CLIP_STATS_EN
        chk("sat_count", clip_count, 3'd7);
`endif

        // ---------------- 5: async reset with beats in flight ----------------
        drive({16'd1, 16'd2}, {16'd3, 16'd4}, 1'b0);
        tick();
        drive({16'd5, 16'd6}, {16'd7, 16'd8}, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ar_inflight", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_sum", sum, 32'd0);
        chk("ar_flag", clip_flag, 2'b00);
`ifdef ADDSUB_CLIP_STATS_EN
        chk("ar_count", clip_count, 3'd0);
`endif
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_dropped", out_valid, 1'b0);
        drive({16'd10, 16'd20}, {16'd1, 16'd2}, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ar_lat1", out_valid, 1'b0);
        tick();
        chk("ar_new_valid", out_valid, 1'b1);
        chk("ar_new_sum", sum, {16'd11, 16'd22});
        tick();
        chk("ar_drained", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
